// File: rtl/midterm_demux_capture.sv
// Receiving end of the three-source channel mux: captures the shared bus word
// into registered C/K/F channels with valid/ack handshake and overflow flags.
module midterm_demux_capture #(
    parameter int WIDTH      = 4,
    parameter bit STICKY_OVF = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] z,
    input  logic [1:0]       sel,
    input  logic             load,
    input  logic             auto,
    input  logic [2:0]       ack,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] F,
    output logic [2:0]       valid,
    output logic [2:0]       ovf,
    output logic             bad_sel,
    output logic [1:0]       next_sel
);

    typedef enum logic [1:0] {
        SEL_C   = 2'b00,
        SEL_K   = 2'b01,
        SEL_F   = 2'b10,
        SEL_RSV = 2'b11
    } sel_e;

    logic [WIDTH-1:0] r_data [3];
    logic [2:0]       r_valid;
    logic [2:0]       r_ovf;
    logic             r_bad_sel;
    logic [1:0]       r_ptr;

    sel_e             w_eff;
    logic [2:0]       w_hit;
    logic [1:0]       w_ptr_nxt;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_eff     = sel_e'(auto ? r_ptr : sel);
        w_hit     = 3'b000;
        w_ptr_nxt = (r_ptr == SEL_F) ? SEL_C : r_ptr + 2'd1;
        if (load) begin
            unique case (w_eff)
                SEL_C:   w_hit[0] = 1'b1;
                SEL_K:   w_hit[1] = 1'b1;
                SEL_F:   w_hit[2] = 1'b1;
                default: w_hit    = 3'b000;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the channel
    // registers are few enough that every one of them is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_data[i] <= '0;
            end
            r_valid   <= 3'b000;
            r_ovf     <= 3'b000;
            r_bad_sel <= 1'b0;
            r_ptr     <= SEL_C;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_hit[i]) begin
                    // A same-cycle ack consumes the old word, so only an unacked overwrite is an overflow.
                    r_data[i]  <= z;
                    r_valid[i] <= 1'b1;
                    if (r_valid[i] && !ack[i]) begin
                        r_ovf[i] <= 1'b1;
                    end
                end else if (ack[i] && r_valid[i]) begin
                    r_valid[i] <= 1'b0;
                    if (!STICKY_OVF) begin
                        r_ovf[i] <= 1'b0;
                    end
                end
            end
            r_bad_sel <= load && (w_eff == SEL_RSV);
            if (load && auto) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign C        = r_data[0];
    assign K        = r_data[1];
    assign F        = r_data[2];
    assign valid    = r_valid;
    assign ovf      = r_ovf;
    assign bad_sel  = r_bad_sel;
    assign next_sel = r_ptr;

endmodule

// File: doc/midterm_demux_capture.md
Name: midterm_demux_capture

Overview:
- Receiving end of the three-source 4-bit channel mux (C/K/F on a shared bus, 2-bit select).
- Routes the shared bus word `z` into one of three registered channel outputs (C, K, F).
- Each channel has a valid/ack handshake and overflow detection.
- An optional auto mode uses an internal round-robin pointer in place of the external select.

Parameters:
- WIDTH, 4, bit width of the shared bus and of each channel register.
- STICKY_OVF, 1, 1 = overflow flags are cleared only by reset; 0 = a channel's ack also clears its overflow flag.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- z  input  WIDTH  shared bus data word.
- sel  input  2  channel select: 00=C, 01=K, 10=F, 11=reserved (no channel).
- load  input  1  capture strobe, one word per asserted cycle.
- auto  input  1  1 = use the internal pointer instead of sel.
- ack  input  3  consumer acknowledge: bit0=C, bit1=K, bit2=F.
- C  output  WIDTH  channel C holding register.
- K  output  WIDTH  channel K holding register.
- F  output  WIDTH  channel F holding register.
- valid  output  3  per-channel data-valid flags (bit0=C, bit1=K, bit2=F).
- ovf  output  3  per-channel overflow flags (same bit order).
- bad_sel  output  1  one-cycle pulse on a load to the reserved select.
- next_sel  output  2  current auto pointer value.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-operation):
  - C=K=F=0, valid=000, ovf=000, bad_sel=0, pointer=00.
  - All state is held while rst_n=0.
  - The first capture is possible on the first rising edge after rst_n deasserts.
- Effective select: eff = auto ? pointer : sel. It is evaluated combinationally in the load cycle.
- Capture, when load=1 and eff is in {00,01,10}:
  - On the next rising edge, the target register takes z and its valid bit sets.
  - Latency is 1 cycle: the data and valid are visible the cycle after load.
  - Non-targeted registers and valid bits are unchanged, apart from their own acks.
- Overwrite: a load to a channel whose valid=1 with its ack=0 in the same cycle still writes the new data and sets that channel's ovf bit. The old data is lost.
- Simultaneous load and ack on the same channel: the load wins, valid stays 1 and ovf is not set.
- Ack without a load to that channel: valid bit clears on the next edge.
  - The data register keeps its value.
  - If STICKY_OVF=0, that channel's ovf bit also clears.
  - Ack on a channel with valid=0 has no effect.
- Reserved select (load=1, eff=11):
  - No register or valid bit changes.
  - bad_sel=1 for exactly the next cycle, then returns to 0 unless the condition repeats.
  - The pointer does not advance.
- Auto pointer:
  - 2-bit register that advances on each edge where load=1 and auto=1.
  - Sequence is 00→01→10→00; it never reaches 11.
  - Holds its value when auto=0 or load=0.
  - Toggling auto does not reset it; auto mode resumes from the held value.
  - next_sel always equals the pointer.
- load=0: no captures and no bad_sel; acks are still processed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then auto=0 and load three cycles with (sel,z) = (00,3), (01,A), (10,5). Required: C=3, K=A, F=5 and valid=111, each appearing one cycle after its load; ovf=000.
- C holding valid data, no ack, then load sel=00 with z=7. Required: C=7, ovf[0]=1. Then ack[0]=1 one cycle: valid[0]=0, and ovf[0] stays 1 (STICKY_OVF=1) or clears (STICKY_OVF=0 build).
- load sel=01 with z=9 and ack[1]=1 in the same cycle while valid[1]=1. Required: K=9, valid[1]=1, ovf[1]=0.
- load sel=11 with z=F. Required: bad_sel=1 for one cycle; C/K/F, valid and next_sel unchanged.
- auto=1 and load four consecutive cycles with z=1,2,3,4. Required: C=1 then C=4, K=2, F=3; next_sel steps 01,10,00,01; ovf[0]=1. Then auto=0 and load sel=10 with z=6: F=6, next_sel stays 01.
- rst_n pulled low asynchronously mid-sequence (between clock edges). Required: all outputs and the pointer read 0 immediately, before the next edge.
